spi_share_arbiter: RTL and testbench
====================================

Name: spi_share_arbiter

Overview:
- Shares the single SD-card SPI byte engine between two requesters and owns the card chip-select.
- Requester A is the CPU-side DivMMC port logic; requester B is the hardware boot/sector loader.
- Sits between the requesters and the byte engine. It serialises transfers and locks ownership while the owner holds chip-select low.
- Keeps per-requester read-ahead data, because the engine only presents a transfer's result at the start of the next transfer.

Parameters:
XFER_CYCLES, 17, clk_sys cycles from engine strobe to engine idle (16 engine half-bit cycles plus 1 cycle of margin)

Ports:
clk_sys  in  1  system clock, single clock domain
reset  in  1  asynchronous, active-high reset
enable  in  1  card interface enable; low forces deselect
a_ss_n  in  1  requester A chip-select request, active low
a_tx  in  1  A write strobe, one cycle, data on a_din
a_rx  in  1  A read strobe, one cycle, shifts out 0xFF
a_din  in  8  A transmit byte
a_dout  out  8  A read-ahead byte (result of A's previous completed transfer)
a_busy  out  1  A strobe pending or in flight
a_grant  out  1  A currently owns the engine
b_ss_n, b_tx, b_rx, b_din, b_dout, b_busy, b_grant: same as the A ports, for requester B
eng_tx  out  1  engine transmit strobe
eng_rx  out  1  engine receive strobe
eng_din  out  8  engine transmit byte
eng_dout  in  8  engine data register
spi_ss  out  1  card chip-select, active low

Behaviour:
- Reset values:
  - spi_ss=1; eng_tx=eng_rx=0; eng_din=0.
  - a_dout=b_dout=8'hFF; busy=0; grant=0.
  - owner=NONE; prev_owner=NONE; last_winner=B, so A wins the first tie.
- States:
  - IDLE: no owner, spi_ss=1.
  - LOCKED: owner set, engine idle.
  - XFER: counter running.
- Pending latch:
  - A strobe (tx or rx) with busy low sets that requester's one-deep pending latch, and busy rises the next cycle.
  - A strobe while busy is high is ignored.
  - tx and rx in the same cycle: tx wins.
- Request = pending OR ss_n low.
- IDLE -> LOCKED:
  - Taken on any request while enable=1.
  - Both requesting in the same cycle: the requester that is not last_winner wins; last_winner updates.
  - grant goes high the next cycle.
- LOCKED:
  - spi_ss = owner's ss_n, combinationally.
  - Owner pending -> XFER: eng_tx or eng_rx pulses exactly one cycle, registered; eng_din = latched byte (0xFF for rx).
  - If owner has nothing pending and its ss_n is high -> IDLE, grant drops next cycle.
  - A strobe issued with ss_n high still gets one transfer with spi_ss=1, so card init clocking is supported.
- XFER:
  - Counter loads XFER_CYCLES-1 in the cycle after the strobe.
  - In that same cycle, eng_dout is captured into prev_owner's dout register (discarded if prev_owner=NONE). prev_owner is then set to the current owner.
  - When the counter reaches 0: clear owner pending and busy, return to LOCKED.
- Non-owner strobes stay pending, with busy high, until ownership passes. Ownership never switches during XFER.
- Latency, uncontended: strobe at cycle N -> eng strobe at N+1 (N+2 if a grant is needed first) -> busy low after XFER_CYCLES more cycles.
- enable low:
  - spi_ss=1 immediately.
  - Pending latches cleared; new strobes ignored.
  - Any XFER in flight completes (counter runs), then IDLE; grants 0.
- Reset mid-transfer: all state returns to reset values at once. The engine may finish its transfer, but prev_owner=NONE, so the next capture is discarded.
- Ownership is released only by the owner's ss_n going high, never by timeout.

Decomposition:
- Package spi_share_pkg holds:
  - owner encoding: OWN_NONE, OWN_A, OWN_B;
  - state enum: IDLE, LOCKED, XFER;
  - XFER_CYCLES default;
  - receive filler constant 8'hFF.
- Sub-module spi_req_port, instantiated once per requester, contains:
  - strobe acceptance;
  - pending latch and stored tx byte/direction;
  - busy;
  - the read-ahead dout register with its load enable.

Test Plan:
- Reset, then A: ss_n=0, a_tx with din 0x40 -> a_grant=1, then eng_tx single pulse with eng_din=0x40; spi_ss=0; a_busy high for exactly 17 cycles after the engine strobe.
- Read-ahead: model eng_dout=0x01 at the first A rx start and 0x5A at the second A rx start -> a_dout=0x01 after the first, then 0x5A; b_dout stays 0xFF.
- Contention: A holds ss_n=0 idle, B strobes tx 0x11 -> b_busy high, no eng strobe. A raises ss_n -> b_grant, eng_tx with eng_din=0x11, spi_ss follows b_ss_n.
- Tie: A and B strobe in the same cycle after reset -> A is served first, B next. Repeat the tie -> B is served first.
- Assert reset mid-XFER for 1 cycle -> all outputs at reset values immediately. The next A transfer leaves a_dout=0xFF (capture discarded).
- enable=0 while A is LOCKED with B pending -> spi_ss=1 at once, B pending cleared, grants 0, no eng strobe issued.

Source files
------------

// File: rtl/spi_share_pkg.sv
// Shared types and constants for the SD-card SPI share arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_share_pkg;

   // Which requester currently owns (or last owned) the byte engine.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_A    = 2'd1,
      OWN_B    = 2'd2
   } owner_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCKED = 2'd1,
      XFER   = 2'd2
   } state_e;

   // Engine strobe to engine idle: 16 half-bit cycles plus 1 cycle of margin.
   localparam int XFER_CYCLES_DEF = 17;

   // Byte shifted out on a read strobe.
   localparam logic [7:0] RX_FILL = 8'hFF;

endpackage

// File: rtl/spi_req_port.sv
// One requester's front end: strobe acceptance, one-deep pending latch, busy, read-ahead byte.
// Latency: a strobe is visible on pend_vld in the same cycle; busy rises on the next cycle.
// Backpressure: strobes are dropped while busy is high or enable is low.
//
// Ports: clk_sys/reset; enable; tx/rx/din from the requester; hold keeps an
// in-flight pending alive through enable-low; done clears pending at transfer end;
// ld_en/ld_dat load the read-ahead register; pend_vld/pend_tx/pend_dat to the
// arbiter; busy and dout back to the requester.
module spi_req_port
   import spi_share_pkg::*;
(
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       enable,
   input  logic       tx,
   input  logic       rx,
   input  logic [7:0] din,
   input  logic       hold,
   input  logic       done,
   input  logic       ld_en,
   input  logic [7:0] ld_dat,
   output logic       pend_vld,
   output logic       pend_tx,
   output logic [7:0] pend_dat,
   output logic       busy,
   output logic [7:0] dout
);

   logic       pend_q, pend_d;
   logic       tx_q, tx_d;
   logic [7:0] dat_q, dat_d;
   logic [7:0] dout_q, dout_d;
   logic       accept;

   always_comb begin
      accept = enable & (tx | rx) & ~pend_q;
      pend_d = pend_q;
      tx_d   = tx_q;
      dat_d  = dat_q;
      if (accept) begin
         pend_d = 1'b1;
         tx_d   = tx;                     // tx wins over a simultaneous rx
         dat_d  = tx ? din : RX_FILL;
      end else if (done) begin
         pend_d = 1'b0;
      end else if (!enable && !hold) begin
         pend_d = 1'b0;                   // deselect flushes anything not yet on the wire
      end
      dout_d = ld_en ? ld_dat : dout_q;
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         pend_q <= 1'b0;
         tx_q   <= 1'b0;
         dat_q  <= 8'h00;
         dout_q <= RX_FILL;
      end else begin
         pend_q <= pend_d;
         tx_q   <= tx_d;
         dat_q  <= dat_d;
         dout_q <= dout_d;
      end
   end

   // A fresh strobe is offered to the arbiter in its own cycle so an already
   // granted owner gets its engine strobe one cycle later.
   assign pend_vld = pend_q | accept;
   assign pend_tx  = accept ? tx : tx_q;
   assign pend_dat = accept ? (tx ? din : RX_FILL) : dat_q;
   assign busy     = pend_q;
   assign dout     = dout_q;

endmodule

// File: rtl/spi_share_arbiter.sv
// Shares one SPI byte engine between requester A (CPU port) and B (boot loader); owns card chip-select.
// Latency: strobe N -> engine strobe N+1 (N+2 when a grant is needed) -> busy low XFER_CYCLES later.
// Backpressure: one pending strobe per requester; non-owner strobes wait with busy high until ownership passes.
//
// Ports: clk_sys/reset/enable; a_*/b_* requester interfaces (ss_n, tx, rx, din,
// dout, busy, grant); eng_tx/eng_rx/eng_din/eng_dout to the byte engine; spi_ss to the card.
module spi_share_arbiter
   import spi_share_pkg::*;
#(
   parameter int XFER_CYCLES = XFER_CYCLES_DEF
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       enable,
   input  logic       a_ss_n,
   input  logic       a_tx,
   input  logic       a_rx,
   input  logic [7:0] a_din,
   output logic [7:0] a_dout,
   output logic       a_busy,
   output logic       a_grant,
   input  logic       b_ss_n,
   input  logic       b_tx,
   input  logic       b_rx,
   input  logic [7:0] b_din,
   output logic [7:0] b_dout,
   output logic       b_busy,
   output logic       b_grant,
   output logic       eng_tx,
   output logic       eng_rx,
   output logic [7:0] eng_din,
   input  logic [7:0] eng_dout,
   output logic       spi_ss
);

   localparam int            CW       = (XFER_CYCLES > 2) ? $clog2(XFER_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(XFER_CYCLES - 1);

   state_e        state_q, state_d;
   owner_e        owner_q, owner_d;
   owner_e        prev_owner_q, prev_owner_d;
   owner_e        last_win_q, last_win_d;
   owner_e        win;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          eng_tx_q, eng_tx_d;
   logic          eng_rx_q, eng_rx_d;
   logic [7:0]    eng_din_q, eng_din_d;
   logic          a_grant_q, a_grant_d;
   logic          b_grant_q, b_grant_d;

   logic       a_pend_vld, a_pend_tx, b_pend_vld, b_pend_tx;
   logic [7:0] a_pend_dat, b_pend_dat;
   logic       a_req, b_req;
   logic       own_pend, own_tx, own_ss_n;
   logic [7:0] own_dat;
   logic       eng_stb, capture, xfer_end;

   assign a_req    = a_pend_vld | ~a_ss_n;
   assign b_req    = b_pend_vld | ~b_ss_n;
   assign eng_stb  = eng_tx_q | eng_rx_q;
   // The engine shows the previous transfer's result while this one starts.
   assign capture  = (state_q == XFER) & eng_stb;
   assign xfer_end = (state_q == XFER) & ~eng_stb & (cnt_q == '0);

   spi_req_port u_port_a (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .enable   (enable),
      .tx       (a_tx),
      .rx       (a_rx),
      .din      (a_din),
      .hold     ((state_q == XFER) && (owner_q == OWN_A)),
      .done     (xfer_end && (owner_q == OWN_A)),
      .ld_en    (capture && (prev_owner_q == OWN_A)),
      .ld_dat   (eng_dout),
      .pend_vld (a_pend_vld),
      .pend_tx  (a_pend_tx),
      .pend_dat (a_pend_dat),
      .busy     (a_busy),
      .dout     (a_dout)
   );

   spi_req_port u_port_b (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .enable   (enable),
      .tx       (b_tx),
      .rx       (b_rx),
      .din      (b_din),
      .hold     ((state_q == XFER) && (owner_q == OWN_B)),
      .done     (xfer_end && (owner_q == OWN_B)),
      .ld_en    (capture && (prev_owner_q == OWN_B)),
      .ld_dat   (eng_dout),
      .pend_vld (b_pend_vld),
      .pend_tx  (b_pend_tx),
      .pend_dat (b_pend_dat),
      .busy     (b_busy),
      .dout     (b_dout)
   );

   always_comb begin
      own_pend = 1'b0;
      own_tx   = 1'b0;
      own_dat  = RX_FILL;
      own_ss_n = 1'b1;
      case (owner_q)
         OWN_A: begin
            own_pend = a_pend_vld;
            own_tx   = a_pend_tx;
            own_dat  = a_pend_dat;
            own_ss_n = a_ss_n;
         end
         OWN_B: begin
            own_pend = b_pend_vld;
            own_tx   = b_pend_tx;
            own_dat  = b_pend_dat;
            own_ss_n = b_ss_n;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      prev_owner_d = prev_owner_q;
      last_win_d   = last_win_q;
      cnt_d        = cnt_q;
      eng_tx_d     = 1'b0;
      eng_rx_d     = 1'b0;
      eng_din_d    = eng_din_q;
      a_grant_d    = a_grant_q;
      b_grant_d    = b_grant_q;
      win          = OWN_NONE;
      case (state_q)
         IDLE: begin
            if (enable && (a_req || b_req)) begin
               if (a_req && b_req) begin
                  // Tie: alternate, so only ties move the last winner.
                  win        = (last_win_q == OWN_B) ? OWN_A : OWN_B;
                  last_win_d = win;
               end else begin
                  win = a_req ? OWN_A : OWN_B;
               end
               state_d   = LOCKED;
               owner_d   = win;
               a_grant_d = (win == OWN_A);
               b_grant_d = (win == OWN_B);
            end
         end
         LOCKED: begin
            if (!enable || (!own_pend && own_ss_n)) begin
               state_d   = IDLE;
               owner_d   = OWN_NONE;
               a_grant_d = 1'b0;
               b_grant_d = 1'b0;
            end else if (own_pend) begin
               state_d   = XFER;
               eng_tx_d  = own_tx;
               eng_rx_d  = ~own_tx;
               eng_din_d = own_dat;
            end
         end
         XFER: begin
            if (eng_stb) begin
               cnt_d        = CNT_LOAD;
               prev_owner_d = owner_q;
            end else if (cnt_q == '0) begin
               if (enable) begin
                  state_d = LOCKED;
               end else begin
                  state_d = IDLE;
                  owner_d = OWN_NONE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (!enable) begin
         a_grant_d = 1'b0;
         b_grant_d = 1'b0;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= OWN_NONE;
         prev_owner_q <= OWN_NONE;
         last_win_q   <= OWN_B;
         cnt_q        <= '0;
         eng_tx_q     <= 1'b0;
         eng_rx_q     <= 1'b0;
         eng_din_q    <= 8'h00;
         a_grant_q    <= 1'b0;
         b_grant_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         prev_owner_q <= prev_owner_d;
         last_win_q   <= last_win_d;
         cnt_q        <= cnt_d;
         eng_tx_q     <= eng_tx_d;
         eng_rx_q     <= eng_rx_d;
         eng_din_q    <= eng_din_d;
         a_grant_q    <= a_grant_d;
         b_grant_q    <= b_grant_d;
      end
   end

   assign eng_tx  = eng_tx_q;
   assign eng_rx  = eng_rx_q;
   assign eng_din = eng_din_q;
   assign a_grant = a_grant_q;
   assign b_grant = b_grant_q;
   // Chip-select follows the owner's request directly; deselect is immediate on enable low.
   assign spi_ss  = (!enable || (state_q == IDLE)) ? 1'b1 : own_ss_n;

endmodule

// File: tb/tb_spi_share_arbiter.sv
// Testbench for spi_share_arbiter: directed stimulus, engine-strobe scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_share_arbiter;

   logic       clk_sys = 1'b0;
   logic       reset, enable;
   logic       a_ss_n, a_tx, a_rx, b_ss_n, b_tx, b_rx;
   logic [7:0] a_din, b_din, a_dout, b_dout, eng_din;
   logic       a_busy, a_grant, b_busy, b_grant, eng_tx, eng_rx, spi_ss;
   logic [7:0] eng_dout = 8'h00;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      bit         tx;
      logic [7:0] din;
      logic       a_g;
      logic       b_g;
      logic       ss;
      logic [7:0] rdat;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk_sys = ~clk_sys;

   spi_share_arbiter dut (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .enable   (enable),
      .a_ss_n   (a_ss_n),
      .a_tx     (a_tx),
      .a_rx     (a_rx),
      .a_din    (a_din),
      .a_dout   (a_dout),
      .a_busy   (a_busy),
      .a_grant  (a_grant),
      .b_ss_n   (b_ss_n),
      .b_tx     (b_tx),
      .b_rx     (b_rx),
      .b_din    (b_din),
      .b_dout   (b_dout),
      .b_busy   (b_busy),
      .b_grant  (b_grant),
      .eng_tx   (eng_tx),
      .eng_rx   (eng_rx),
      .eng_din  (eng_din),
      .eng_dout (eng_dout),
      .spi_ss   (spi_ss)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic push(input bit tx, input logic [7:0] din, input logic ag, input logic bg,
                       input logic ss, input logic [7:0] rdat);
      exp_t e;
      e.tx = tx; e.din = din; e.a_g = ag; e.b_g = bg; e.ss = ss; e.rdat = rdat;
      exp_q.push_back(e);
   endtask

   task automatic strobe(input bit is_b, input bit is_tx, input logic [7:0] d);
      if (is_b) begin b_tx = is_tx; b_rx = !is_tx; b_din = d; end
      else      begin a_tx = is_tx; a_rx = !is_tx; a_din = d; end
      tick(1);
      a_tx = 1'b0; a_rx = 1'b0; b_tx = 1'b0; b_rx = 1'b0;
   endtask

   // Called in the cycle after a strobe: measures strobe latency and busy cycles after the engine strobe.
   task automatic xfer_wait(input bit is_b, output int lat, output int bcyc);
      lat = 1;
      while (!(eng_tx || eng_rx) && lat < 20) begin
         tick(1);
         lat++;
      end
      chk("eng_strobe_timeout", 8'(lat < 20), 8'd1);
      bcyc = 0;
      tick(1);
      while ((is_b ? b_busy : a_busy) && bcyc < 60) begin
         bcyc++;
         tick(1);
      end
   endtask

   task automatic wait_free();
      int k = 0;
      while ((a_busy || b_busy) && k < 200) begin
         tick(1);
         k++;
      end
      chk("wait_free_timeout", 8'(k < 200), 8'd1);
   endtask

   // Monitor: every engine strobe must match the head of the expectation queue.
   // It also plays the engine's data register for the next capture.
   always @(negedge clk_sys) begin
      if (!reset && (eng_tx || eng_rx)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_eng_strobe_qsize", 8'(exp_q.size()), 8'd1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("eng_kind", {6'd0, eng_tx, eng_rx}, {6'd0, e.tx, !e.tx});
            chk("eng_din", eng_din, e.din);
            chk("grants_at_strobe", {6'd0, a_grant, b_grant}, {6'd0, e.a_g, e.b_g});
            chk("spi_ss_at_strobe", {7'd0, spi_ss}, {7'd0, e.ss});
            eng_dout = e.rdat;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, bcyc;
      reset = 1'b1; enable = 1'b1;
      a_ss_n = 1'b1; a_tx = 1'b0; a_rx = 1'b0; a_din = 8'h00;
      b_ss_n = 1'b1; b_tx = 1'b0; b_rx = 1'b0; b_din = 8'h00;
      #2;
      chk("rst_spi_ss", {7'd0, spi_ss}, 8'd1);
      chk("rst_eng_strobes", {6'd0, eng_tx, eng_rx}, 8'd0);
      chk("rst_eng_din", eng_din, 8'h00);
      chk("rst_a_dout", a_dout, 8'hFF);
      chk("rst_b_dout", b_dout, 8'hFF);
      chk("rst_busy", {6'd0, a_busy, b_busy}, 8'd0);
      chk("rst_grants", {6'd0, a_grant, b_grant}, 8'd0);
      tick(2);
      reset = 1'b0;
      tick(2);

      // Basic A write with grant acquisition.
      a_ss_n = 1'b0;
      push(1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 8'hEE);
      strobe(1'b0, 1'b1, 8'h40);
      chk("a_grant_after_req", {7'd0, a_grant}, 8'd1);
      chk("a_busy_after_strobe", {7'd0, a_busy}, 8'd1);
      xfer_wait(1'b0, lat, bcyc);
      chk("a_tx_latency", 8'(lat), 8'd2);
      chk("a_busy_cycles", 8'(bcyc), 8'd17);
      chk("spi_ss_locked_a", {7'd0, spi_ss}, 8'd0);
      chk("a_dout_first_discard", a_dout, 8'hFF);

      // Read-ahead: two A reads.
      push(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h01);
      strobe(1'b0, 1'b0, 8'h00);
      xfer_wait(1'b0, lat, bcyc);
      chk("a_rx_latency_granted", 8'(lat), 8'd1);
      chk("a_dout_rd1", a_dout, 8'h01);
      push(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h5A);
      strobe(1'b0, 1'b0, 8'h00);
      xfer_wait(1'b0, lat, bcyc);
      chk("a_dout_rd2", a_dout, 8'h5A);
      chk("b_dout_untouched", b_dout, 8'hFF);

      // Contention: A holds the card idle, B must wait.
      b_ss_n = 1'b0;
      push(1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h77);
      strobe(1'b1, 1'b1, 8'h11);
      chk("b_busy_waiting", {7'd0, b_busy}, 8'd1);
      tick(4);
      chk("b_still_waiting_no_strobe", {5'd0, b_busy, eng_tx, eng_rx}, 8'h04);
      chk("b_grant_while_a_owns", {7'd0, b_grant}, 8'd0);
      a_ss_n = 1'b1;
      tick(1);
      wait_free();
      chk("b_grant_after_release", {6'd0, a_grant, b_grant}, 8'd1);
      chk("spi_ss_follows_b_low", {7'd0, spi_ss}, 8'd0);
      b_ss_n = 1'b1;
      #1;
      chk("spi_ss_follows_b_high", {7'd0, spi_ss}, 8'd1);
      chk("a_dout_from_b_xfer", a_dout, 8'h77);
      chk("b_dout_after_contention", b_dout, 8'hFF);
      tick(2);

      // Tie after reset: A first, then B; repeated tie: B first.
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(1);
      push(1'b1, 8'h21, 1'b1, 1'b0, 1'b1, 8'h00);
      push(1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h00);
      a_tx = 1'b1; a_din = 8'h21; b_tx = 1'b1; b_din = 8'h22;
      tick(1);
      a_tx = 1'b0; b_tx = 1'b0;
      wait_free();
      tick(3);
      push(1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h00);
      push(1'b1, 8'h34, 1'b1, 1'b0, 1'b1, 8'h00);
      a_tx = 1'b1; a_din = 8'h34; b_tx = 1'b1; b_din = 8'h33;
      tick(1);
      a_tx = 1'b0; b_tx = 1'b0;
      wait_free();
      tick(3);
      chk("tie_queue_drained", 8'(exp_q.size()), 8'd0);

      // Reset in the middle of a transfer.
      a_ss_n = 1'b0;
      push(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h3C);
      strobe(1'b0, 1'b1, 8'h55);
      lat = 0;
      while (!(eng_tx || eng_rx) && lat < 20) begin tick(1); lat++; end
      tick(3);
      chk("mid_xfer_a_busy", {7'd0, a_busy}, 8'd1);
      chk("mid_xfer_a_dout", a_dout, 8'h3C);
      reset = 1'b1;
      #1;
      chk("mrst_spi_ss", {7'd0, spi_ss}, 8'd1);
      chk("mrst_busy_grant", {4'd0, a_busy, b_busy, a_grant, b_grant}, 8'd0);
      chk("mrst_a_dout", a_dout, 8'hFF);
      chk("mrst_eng_din", eng_din, 8'h00);
      tick(1);
      reset = 1'b0;
      tick(1);
      push(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h99);
      strobe(1'b0, 1'b0, 8'h00);
      xfer_wait(1'b0, lat, bcyc);
      chk("post_rst_a_dout_discard", a_dout, 8'hFF);

      // Deselect while A is locked and B is pending.
      push(1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 8'h00);   // must never be consumed
      strobe(1'b1, 1'b1, 8'h66);
      chk("b_pending_before_disable", {7'd0, b_busy}, 8'd1);
      enable = 1'b0;
      #1;
      chk("disable_spi_ss_now", {7'd0, spi_ss}, 8'd1);
      tick(1);
      chk("disable_b_busy", {7'd0, b_busy}, 8'd0);
      chk("disable_grants", {6'd0, a_grant, b_grant}, 8'd0);
      strobe(1'b0, 1'b1, 8'h77);
      chk("disable_a_strobe_ignored", {7'd0, a_busy}, 8'd0);
      tick(25);
      chk("disable_no_eng_strobe_qsize", 8'(exp_q.size()), 8'd1);
      void'(exp_q.pop_front());
      a_ss_n = 1'b1;
      enable = 1'b1;
      tick(3);
      chk("final_queue_empty", 8'(exp_q.size()), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
